log_stream_reader: RTL
======================

Name: log_stream_reader

Overview:
- Reader end of the logging buffer's read port.
- On `start`, it walks every stored log entry oldest-first: drives `read_enable`/`read_address`, captures the 128-bit entry, applies a severity filter and serialises accepted entries as framed bytes on a valid/ready byte stream.
- Sits between the logging buffer and the UART/STM32 byte transport.

Parameters:
- LOG_BUFFER_SIZE, 1024, buffer depth; ADDR_WIDTH = $clog2(LOG_BUFFER_SIZE).
- LOG_ENTRY_WIDTH, 128, entry width in bits; fixed at 128 (16 bytes).
- READ_HOLD, 2, number of `read_valid` cycles with a stable address before data is captured.
- TIMEOUT_CYCLES, 16, maximum cycles spent in READ per entry.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  pulse; begin a dump
- abort  in  1  pulse/level; stop the dump at the next frame boundary
- min_severity  in  3  entries with severity field [55:53] below this are skipped
- entries_count  in  ADDR_WIDTH  stored entry count from the buffer
- read_enable  out  1  buffer read request
- read_address  out  ADDR_WIDTH  logical index, 0 = oldest
- read_data  in  128  entry from the buffer
- read_valid  in  1  buffer read response
- m_tdata  out  8  stream byte
- m_tvalid  out  1  stream valid
- m_tready  in  1  stream ready
- m_tlast  out  1  high on the last byte of a frame
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse at the end of a dump
- frames_sent  out  32  frames emitted; saturating
- read_timeouts  out  32  entries dropped on timeout; saturating

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; internal index, hold, timeout and byte counters 0; capture register 0.
- Frame format (18 bytes):
  - Byte 0: 0xA5.
  - Bytes 1..16: entry bits [127:120] down to [7:0], MSB byte first.
  - Byte 17: XOR of bytes 1..16, with `m_tlast` = 1.
- FSM states: IDLE, READ, EMIT, NEXT.
- IDLE:
  - On `start`: snapshot `entries_count` into `cnt_snap`, set idx = 0.
  - If `cnt_snap` == 0: pulse `done` the next cycle and stay in IDLE.
  - Otherwise go to READ.
  - `start` while `busy` is ignored.
- READ:
  - Drive `read_enable` = 1 and `read_address` = idx, held stable for the whole state.
  - `hold_cnt` increments on each cycle with `read_valid` = 1.
  - When `read_valid` && `hold_cnt` == READ_HOLD-1: capture `read_data`.
    - Captured severity >= `min_severity`: go to EMIT.
    - Otherwise: go to NEXT.
  - `tmo_cnt` increments every cycle in READ. When it reaches TIMEOUT_CYCLES-1 without a capture: `read_timeouts` += 1, go to NEXT.
  - `hold_cnt` and `tmo_cnt` clear on entry to READ.
- EMIT:
  - `read_enable` = 0, `m_tvalid` = 1.
  - `byte_idx` advances only on `m_tvalid` && `m_tready`.
  - `m_tdata`/`m_tlast` stay stable while `m_tvalid` && !`m_tready`; `m_tvalid` never drops mid-frame.
  - The checksum is computed from the captured register (combinational or accumulated), not from live `read_data`.
  - After the byte-17 handshake: `frames_sent` += 1, `m_tvalid` = 0 the next cycle, go to NEXT.
- NEXT (one cycle, `read_enable` = 0, giving at least one idle cycle between reads):
  - If idx == `cnt_snap`-1 or `abort_pending`: pulse `done`, clear `abort_pending`, go to IDLE.
  - Otherwise idx += 1, go to READ.
- Abort:
  - `abort` sets `abort_pending`.
  - In READ: taken immediately; go to NEXT without capturing.
  - In EMIT: honoured only after the byte-17 handshake.
  - In IDLE: ignored and not latched.
- Snapshot rule: `entries_count` changes during a dump are ignored; `cnt_snap` is fixed.
- Counter saturation: `frames_sent` and `read_timeouts` saturate at 0xFFFFFFFF. They are not cleared by `start`, only by reset.
- Reset asserted mid-frame: all outputs return to reset values asynchronously; the frame is truncated with no recovery.
- Throughput: minimum 18 cycles per emitted frame with `m_tready` held at 1.

Test Plan:
1. `entries_count`=3, all severity 2, `min_severity`=0, `m_tready`=1, buffer model returns data READ_HOLD cycles after the request -> 3 frames of 18 bytes each; addresses 0,1,2 each held for at least 2 cycles; byte 17 = XOR of bytes 1..16; `frames_sent`=3; one `done` pulse; `busy` low afterwards.
2. Entry 0x0000000000000001_03_..., severity field 1, with `min_severity`=2 -> no bytes emitted for that entry; the next entry with severity 4 is emitted; `frames_sent`=1.
3. `m_tready` toggling 1,0,0,1 across a frame -> `m_tdata`/`m_tlast` stable during stalls; the byte sequence is identical to the `m_tready`=1 case; `m_tvalid` never drops mid-frame.
4. `read_valid` held at 0 for entry 1 of 2 -> after 16 cycles `read_timeouts`=1; entry 1 is skipped; `done` pulses; `frames_sent`=1.
5. `entries_count`=0 with `start` -> `done` pulses one cycle later, no `read_enable`. Also: `start` pulsed while `busy` -> no effect.
6. `abort` asserted at byte 5 of frame 0 of 4 -> frame 0 completes (byte 17 with `tlast`), then `done`; `frames_sent`=1. `rst_n` low mid-frame -> all outputs 0 immediately.

Source files
------------

// File: rtl/log_stream_reader.sv
// Log buffer dump engine. Walks stored entries oldest-first through the buffer read port.
// Drops entries below a minimum severity. Emits each kept entry as an 18-byte frame:
// 0xA5, the 16 entry bytes MSB first, then an XOR checksum of those 16 bytes.
module log_stream_reader #(
  parameter int unsigned LOG_BUFFER_SIZE = 1024,
  parameter int unsigned LOG_ENTRY_WIDTH = 128,
  parameter int unsigned READ_HOLD       = 2,
  parameter int unsigned TIMEOUT_CYCLES  = 16,
  localparam int unsigned ADDR_WIDTH     = $clog2(LOG_BUFFER_SIZE)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_i,
  input  logic                       abort_i,
  input  logic [2:0]                 min_severity_i,
  input  logic [ADDR_WIDTH-1:0]      entries_count_i,
  output logic                       read_enable_o,
  output logic [ADDR_WIDTH-1:0]      read_address_o,
  input  logic [LOG_ENTRY_WIDTH-1:0] read_data_i,
  input  logic                       read_valid_i,
  output logic [7:0]                 m_tdata_o,
  output logic                       m_tvalid_o,
  input  logic                       m_tready_i,
  output logic                       m_tlast_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [31:0]                frames_sent_o,
  output logic [31:0]                read_timeouts_o
);

  localparam int unsigned EntryBytes = LOG_ENTRY_WIDTH / 8;
  localparam int unsigned FrameLen   = EntryBytes + 2;
  localparam int unsigned ByteW      = $clog2(FrameLen);
  localparam int unsigned EbW        = $clog2(EntryBytes);
  localparam int unsigned HoldW      = $clog2(READ_HOLD + 1);
  localparam int unsigned TmoW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ByteW-1:0] LastIdx = ByteW'(FrameLen - 1);
  localparam logic [7:0]       SyncByte = 8'hA5;

  typedef enum logic [1:0] {StIdle, StRead, StEmit, StNext} state_e;

  state_e                     state_q, state_d;
  logic [ADDR_WIDTH-1:0]      cnt_snap_q, cnt_snap_d;
  logic [ADDR_WIDTH-1:0]      idx_q, idx_d;
  logic [HoldW-1:0]           hold_cnt_q, hold_cnt_d;
  logic [TmoW-1:0]            tmo_cnt_q, tmo_cnt_d;
  logic [ByteW-1:0]           byte_idx_q, byte_idx_d;
  logic [LOG_ENTRY_WIDTH-1:0] cap_q, cap_d;
  logic                       abort_pend_q, abort_pend_d;
  logic                       read_enable_q, read_enable_d;
  logic [ADDR_WIDTH-1:0]      read_address_q, read_address_d;
  logic [7:0]                 m_tdata_q, m_tdata_d;
  logic                       m_tvalid_q, m_tvalid_d;
  logic                       m_tlast_q, m_tlast_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic [31:0]                frames_sent_q, frames_sent_d;
  logic [31:0]                read_timeouts_q, read_timeouts_d;

  logic [7:0]       entry_byte [EntryBytes];
  logic [7:0]       cap_xor;
  logic [ByteW-1:0] nxt_idx;
  logic [EbW-1:0]   nxt_sel;
  logic [7:0]       nxt_byte;

  // Split the captured entry into bytes and fold them into the checksum.
  always_comb begin
    cap_xor = 8'h00;
    for (int i = 0; i < int'(EntryBytes); i++) begin
      entry_byte[i] = cap_q[LOG_ENTRY_WIDTH - 1 - 8 * i -: 8];
      cap_xor       = cap_xor ^ entry_byte[i];
    end
  end

  // Byte presented after the current one is accepted; frame byte n maps to entry byte n-1.
  always_comb begin
    nxt_idx = byte_idx_q + 1'b1;
    nxt_sel = EbW'(nxt_idx - 1'b1);
    if (nxt_idx == LastIdx) begin
      nxt_byte = cap_xor;
    end else begin
      nxt_byte = entry_byte[nxt_sel];
    end
  end

  // Next-state and registered-output logic for the dump FSM.
  always_comb begin
    state_d         = state_q;
    cnt_snap_d      = cnt_snap_q;
    idx_d           = idx_q;
    hold_cnt_d      = hold_cnt_q;
    tmo_cnt_d       = tmo_cnt_q;
    byte_idx_d      = byte_idx_q;
    cap_d           = cap_q;
    abort_pend_d    = abort_pend_q;
    read_enable_d   = read_enable_q;
    read_address_d  = read_address_q;
    m_tdata_d       = m_tdata_q;
    m_tvalid_d      = m_tvalid_q;
    m_tlast_d       = m_tlast_q;
    busy_d          = busy_q;
    done_d          = 1'b0;
    frames_sent_d   = frames_sent_q;
    read_timeouts_d = read_timeouts_q;

    case (state_q)
      StIdle: begin
        if (start_i) begin
          cnt_snap_d = entries_count_i;
          idx_d      = '0;
          if (entries_count_i == '0) begin
            done_d = 1'b1;
          end else begin
            state_d        = StRead;
            busy_d         = 1'b1;
            read_enable_d  = 1'b1;
            read_address_d = '0;
            hold_cnt_d     = '0;
            tmo_cnt_d      = '0;
          end
        end
      end

      StRead: begin
        if (abort_i) begin
          // Abort wins over a same-cycle capture; the entry is not emitted.
          abort_pend_d  = 1'b1;
          read_enable_d = 1'b0;
          state_d       = StNext;
        end else if (read_valid_i && (hold_cnt_q == HoldW'(READ_HOLD - 1))) begin
          cap_d         = read_data_i;
          read_enable_d = 1'b0;
          if (read_data_i[55:53] >= min_severity_i) begin
            state_d    = StEmit;
            m_tvalid_d = 1'b1;
            m_tdata_d  = SyncByte;
            m_tlast_d  = 1'b0;
            byte_idx_d = '0;
          end else begin
            state_d = StNext;
          end
        end else if (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
          if (read_timeouts_q != '1) begin
            read_timeouts_d = read_timeouts_q + 32'd1;
          end
          read_enable_d = 1'b0;
          state_d       = StNext;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
          if (read_valid_i) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
      end

      StEmit: begin
        // Abort is only latched here; the frame always runs to its last byte.
        if (abort_i) begin
          abort_pend_d = 1'b1;
        end
        if (m_tready_i) begin
          if (byte_idx_q == LastIdx) begin
            m_tvalid_d = 1'b0;
            m_tlast_d  = 1'b0;
            m_tdata_d  = 8'h00;
            if (frames_sent_q != '1) begin
              frames_sent_d = frames_sent_q + 32'd1;
            end
            state_d = StNext;
          end else begin
            byte_idx_d = nxt_idx;
            m_tdata_d  = nxt_byte;
            m_tlast_d  = (nxt_idx == LastIdx);
          end
        end
      end

      StNext: begin
        if ((idx_q == cnt_snap_q - 1'b1) || abort_pend_q || abort_i) begin
          done_d       = 1'b1;
          abort_pend_d = 1'b0;
          busy_d       = 1'b0;
          state_d      = StIdle;
        end else begin
          idx_d          = idx_q + 1'b1;
          read_address_d = idx_q + 1'b1;
          read_enable_d  = 1'b1;
          hold_cnt_d     = '0;
          tmo_cnt_d      = '0;
          state_d        = StRead;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset clears everything, truncating any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      cnt_snap_q      <= '0;
      idx_q           <= '0;
      hold_cnt_q      <= '0;
      tmo_cnt_q       <= '0;
      byte_idx_q      <= '0;
      cap_q           <= '0;
      abort_pend_q    <= 1'b0;
      read_enable_q   <= 1'b0;
      read_address_q  <= '0;
      m_tdata_q       <= 8'h00;
      m_tvalid_q      <= 1'b0;
      m_tlast_q       <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      frames_sent_q   <= '0;
      read_timeouts_q <= '0;
    end else begin
      state_q         <= state_d;
      cnt_snap_q      <= cnt_snap_d;
      idx_q           <= idx_d;
      hold_cnt_q      <= hold_cnt_d;
      tmo_cnt_q       <= tmo_cnt_d;
      byte_idx_q      <= byte_idx_d;
      cap_q           <= cap_d;
      abort_pend_q    <= abort_pend_d;
      read_enable_q   <= read_enable_d;
      read_address_q  <= read_address_d;
      m_tdata_q       <= m_tdata_d;
      m_tvalid_q      <= m_tvalid_d;
      m_tlast_q       <= m_tlast_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      frames_sent_q   <= frames_sent_d;
      read_timeouts_q <= read_timeouts_d;
    end
  end

  assign read_enable_o   = read_enable_q;
  assign read_address_o  = read_address_q;
  assign m_tdata_o       = m_tdata_q;
  assign m_tvalid_o      = m_tvalid_q;
  assign m_tlast_o       = m_tlast_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign frames_sent_o   = frames_sent_q;
  assign read_timeouts_o = read_timeouts_q;

endmodule
